// File: rtl/riscv_uop_pkg.sv
// Shared fetch-side types and constants: fetch FSM state, the canonical NOP
// encoding, and a word-alignment helper used wherever a fetch address is loaded.
package riscv_uop_pkg;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_RUN   = 2'd1,
    FS_DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] FETCH_NOP = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO used for both the pending-PC list and the
// instruction queue. Synchronous clear drops every entry in one cycle.
module fetch_fifo
  import riscv_uop_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop = pop && !empty;
  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign dout   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end

  // Storage array; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word requests to instruction memory under a
// credit limit, tracks in-flight requests, queues returned instructions for
// decode and discards stale responses after a redirect.
// Optional feature: define FETCH_PERF_CNT_EN to add the fetched-instruction and
// decode-stall performance counters.
module fetch_stage
  import riscv_uop_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] o_perf_fetched,
  output logic [31:0] o_perf_stall_cyc
`endif
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] flush_drop;
  logic [CW-1:0] fq_count;
  logic [CW-1:0] pend_count;
  logic [CW:0]   credit_used;
  logic [31:0]   pend_pc;
  logic [63:0]   fq_head;
  logic          fq_empty, fq_full, pend_empty, pend_full;
  logic          grant, rsp_seen, rsp_take, fq_pop;

  assign credit_used = {1'b0, outstanding} + {1'b0, fq_count};
  assign o_imem_req  = (state == FS_RUN) && !i_flush &&
                       (credit_used < (CW+1)'(FQ_DEPTH));
  assign o_imem_addr = fetch_pc;

  assign grant      = o_imem_req && i_imem_gnt;
  assign rsp_seen   = i_imem_rvalid && (outstanding != '0);
  assign rsp_take   = rsp_seen && (drop_cnt == '0) && !i_flush;
  assign fq_pop     = !fq_empty && !i_stall && !i_flush;
  assign flush_drop = outstanding - CW'(rsp_seen);

  assign o_if_valid = !fq_empty;
  assign o_if_pc    = o_if_valid ? fq_head[63:32] : '0;
  assign o_if_instr = o_if_valid ? fq_head[31:0]  : '0;

  fetch_fifo #(.WIDTH(32), .DEPTH(FQ_DEPTH)) u_pend_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (i_flush),
    .push  (grant),
    .din   (fetch_pc),
    .pop   (rsp_take),
    .dout  (pend_pc),
    .full  (pend_full),
    .empty (pend_empty),
    .count (pend_count)
  );

  fetch_fifo #(.WIDTH(64), .DEPTH(FQ_DEPTH)) u_instr_queue (
    .clk   (clk),
    .rst   (rst),
    .clr   (i_flush),
    .push  (rsp_take),
    .din   ({pend_pc, i_imem_rdata}),
    .pop   (fq_pop),
    .dout  (fq_head),
    .full  (fq_full),
    .empty (fq_empty),
    .count (fq_count)
  );

  // Fetch FSM: boot delay, redirect handling, stale-response draining and PC advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FS_BOOT;
      fetch_pc    <= word_align(RESET_PC);
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (grant && !rsp_seen) begin
        outstanding <= outstanding + 1'b1;
      end else if (rsp_seen && !grant) begin
        outstanding <= outstanding - 1'b1;
      end
      if (i_flush) begin
        fetch_pc <= word_align(i_redirect_pc);
        drop_cnt <= flush_drop;
        state    <= (flush_drop != '0) ? FS_DRAIN : FS_RUN;
      end else begin
        case (state)
          FS_BOOT: state <= FS_RUN;
          FS_RUN: begin
            if (grant) fetch_pc <= fetch_pc + 32'd4;
          end
          FS_DRAIN: begin
            if (rsp_seen && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
            if ((drop_cnt == '0) || (rsp_seen && (drop_cnt == CW'(1)))) state <= FS_RUN;
          end
          default: state <= FS_BOOT;
        endcase
      end
    end
  end

  // The pending-PC list mirrors the non-stale in-flight requests; neither FIFO may overflow.
  a_pend_track: assert property (@(posedge clk) disable iff (rst)
    pend_count == (outstanding - drop_cnt));
  a_pend_over:  assert property (@(posedge clk) disable iff (rst) !(grant && pend_full));
  a_pend_under: assert property (@(posedge clk) disable iff (rst) !(rsp_take && pend_empty));
  a_fq_over:    assert property (@(posedge clk) disable iff (rst) !(rsp_take && fq_full));

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters of instructions handed to decode and decode-stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_perf_fetched   <= '0;
      o_perf_stall_cyc <= '0;
    end else begin
      if (fq_pop && (o_perf_fetched != '1)) o_perf_fetched <= o_perf_fetched + 32'd1;
      if (o_if_valid && i_stall && (o_perf_stall_cyc != '1))
        o_perf_stall_cyc <= o_perf_stall_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: an in-order instruction memory with random latency,
// a transaction-level model of what decode must see, directed scenarios and a
// randomized run.
module tb_fetch_stage;
  import riscv_uop_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_stall = 1'b0, i_flush = 1'b0, i_imem_gnt = 1'b0, i_imem_rvalid = 1'b0;
  logic [31:0] i_redirect_pc = '0, i_imem_rdata = '0;
  logic        o_imem_req, o_if_valid;
  logic [31:0] o_imem_addr, o_if_pc, o_if_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall_cyc;
`endif

  fetch_stage #(.RESET_PC(RST_PC), .FQ_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_stall       (i_stall),
    .i_flush       (i_flush),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_if_valid    (o_if_valid),
    .o_if_pc       (o_if_pc),
    .o_if_instr    (o_if_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_perf_fetched   (perf_fetched),
    .o_perf_stall_cyc (perf_stall_cyc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int ready; } mem_req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } fq_ent_t;

  mem_req_t    mem_q[$];
  fq_ent_t     fq[$];
  logic [31:0] model_pc;
  int          epoch = 0, cyc = 0, lat = 1;
  bit          boot = 1'b1;
  int          checks = 0, errors = 0;

  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_pc, obs_instr;
  logic [31:0] gnt_addrs[$];
  logic [31:0] pop_pcs[$];

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Called at a negedge; drives one cycle, checks outputs, advances the model, returns at next negedge.
  task automatic applyStimulus(input logic stall, input logic flush, input logic [31:0] redir,
                               input logic gnt);
    logic     rv, exp_req, exp_valid, exp_pop;
    int       stale;
    mem_req_t head;
    head = '{addr: 32'h0, epoch: -1, ready: 0};
    cyc++;
    rv = (mem_q.size() > 0) && (mem_q[0].ready <= cyc);
    i_stall       = stall;
    i_flush       = flush;
    i_redirect_pc = redir;
    i_imem_gnt    = gnt;
    i_imem_rvalid = rv;
    i_imem_rdata  = rv ? instrOf(mem_q[0].addr) : $urandom();
    stale = 0;
    foreach (mem_q[k]) if (mem_q[k].epoch != epoch) stale++;
    exp_req   = !boot && !flush && (stale == 0) && ((mem_q.size() + fq.size()) < DEPTH);
    exp_valid = (fq.size() != 0);
    exp_pop   = exp_valid && !stall && !flush;
    #1;
    obs_req = o_imem_req; obs_addr = o_imem_addr; obs_valid = o_if_valid;
    obs_pc = o_if_pc; obs_instr = o_if_instr;
    if (o_imem_req && gnt) gnt_addrs.push_back(o_imem_addr);
    if (o_if_valid && !stall && !flush) pop_pcs.push_back(o_if_pc);
    checkOutput("imem_req", 32'(o_imem_req), 32'(exp_req));
    checkOutput("addr_align", 32'(o_imem_addr[1:0]), 32'h0);
    if (exp_req) checkOutput("imem_addr", o_imem_addr, model_pc);
    checkOutput("if_valid", 32'(o_if_valid), 32'(exp_valid));
    if (exp_valid) begin
      checkOutput("if_pc", o_if_pc, fq[0].pc);
      checkOutput("if_instr", o_if_instr, fq[0].instr);
    end
    if (rv) head = mem_q.pop_front();
    if (flush) begin
      fq.delete();
      model_pc = word_align(redir);
      epoch++;
    end else begin
      if (exp_pop) void'(fq.pop_front());
      if (rv && (head.epoch == epoch)) fq.push_back('{pc: head.addr, instr: instrOf(head.addr)});
      if (exp_req && gnt) begin
        mem_q.push_back('{addr: model_pc, epoch: epoch, ready: cyc + lat});
        model_pc = model_pc + 32'd4;
      end
    end
    boot = 1'b0;
    @(negedge clk);
  endtask

  // Asserts reset between clock edges, checks the immediate effect, releases at a negedge.
  task automatic applyReset();
    #2;
    rst = 1'b1;
    i_stall = 0; i_flush = 0; i_imem_gnt = 0; i_imem_rvalid = 0;
    #1;
    checkOutput("rst_imem_req", 32'(o_imem_req), 32'h0);
    checkOutput("rst_if_valid", 32'(o_if_valid), 32'h0);
    checkOutput("rst_if_pc", o_if_pc, 32'h0);
    checkOutput("rst_if_instr", o_if_instr, 32'h0);
    checkOutput("rst_state", 32'(dut.state), 32'(FS_BOOT));
    mem_q.delete(); fq.delete();
    model_pc = RST_PC; boot = 1'b1; cyc = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  // Steps until two requests are in flight and no response is due next cycle.
  task automatic fillTwoOutstanding(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      if (mem_q.size() == 2) ok = 1'b1;
      else applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    end
    if (!ok) checkOutput(tag, 32'h0, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit found;
    @(negedge clk);

    // Boot sequence and in-order delivery.
    applyReset(); lat = 1;
    pop_pcs.delete();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("boot_no_req", 32'(obs_req), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("c2_req", 32'(obs_req), 32'h1);
    checkOutput("c2_addr", obs_addr, RST_PC);
    repeat (12) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("s1_npops", 32'(pop_pcs.size() >= 3), 32'h1);
    for (int i = 0; i < 3 && i < pop_pcs.size(); i++)
      checkOutput("s1_pc_seq", pop_pcs[i], RST_PC + 32'(4 * i));

    // Decode stall: head held, credits exhausted, nothing lost afterwards.
    applyReset(); lat = 1;
    gnt_addrs.delete(); pop_pcs.delete();
    repeat (12) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      if (obs_valid) begin
        checkOutput("stall_head_pc", obs_pc, RST_PC);
        checkOutput("stall_head_instr", obs_instr, instrOf(RST_PC));
      end
    end
    checkOutput("stall_grants", 32'(gnt_addrs.size()), 32'(DEPTH));
    repeat (16) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("stall_release_npops", 32'(pop_pcs.size() >= 4), 32'h1);
    for (int i = 0; i < 4 && i < pop_pcs.size(); i++)
      checkOutput("stall_release_seq", pop_pcs[i], RST_PC + 32'(4 * i));

    // Redirect with two requests in flight.
    applyReset(); lat = 6;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    fillTwoOutstanding("s3_setup_timeout");
    gnt_addrs.delete(); pop_pcs.delete();
    applyStimulus(1'b0, 1'b1, 32'h0000_0102, 1'b1);
    checkOutput("s3_state_drain", 32'(dut.state), 32'(FS_DRAIN));
    lat = 1;
    repeat (20) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("s3_first_req", (gnt_addrs.size() > 0) ? gnt_addrs[0] : 32'hDEAD_BEEF, 32'h0000_0100);
    checkOutput("s3_first_pop", (pop_pcs.size() > 0) ? pop_pcs[0] : 32'hDEAD_BEEF, 32'h0000_0100);

    // Redirect coinciding with a response under stall.
    applyReset(); lat = 4;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (mem_q.size() == 2 && mem_q[0].ready <= cyc + 1) found = 1'b1;
      else applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    end
    if (!found) checkOutput("s4_setup_timeout", 32'h0, 32'h1);
    pop_pcs.delete();
    applyStimulus(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    checkOutput("s4_state_drain", 32'(dut.state), 32'(FS_DRAIN));
    checkOutput("s4_drop_cnt", 32'(dut.drop_cnt), 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("s4_state_run", 32'(dut.state), 32'(FS_RUN));
    checkOutput("s4_drop_zero", 32'(dut.drop_cnt), 32'h0);
    lat = 1;
    repeat (8) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("s4_first_pop", (pop_pcs.size() > 0) ? pop_pcs[0] : 32'hDEAD_BEEF, 32'h0000_0200);

    // Fetch PC wrap, with the redirect landing in the boot cycle.
    applyReset(); lat = 1;
    gnt_addrs.delete();
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    repeat (8) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("wrap_req0", (gnt_addrs.size() > 0) ? gnt_addrs[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    checkOutput("wrap_req1", (gnt_addrs.size() > 1) ? gnt_addrs[1] : 32'hDEAD_BEEF, 32'h0000_0000);

    // Reset while draining stale responses.
    applyReset(); lat = 6;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    fillTwoOutstanding("s6_setup_timeout");
    applyStimulus(1'b0, 1'b1, 32'h0000_0040, 1'b1);
    checkOutput("s6_state_drain", 32'(dut.state), 32'(FS_DRAIN));
    applyReset(); lat = 1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("s6_boot_no_req", 32'(obs_req), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("s6_restart_req", 32'(obs_req), 32'h1);
    checkOutput("s6_restart_addr", obs_addr, RST_PC);

    // Randomized traffic against the model, with one reset in the middle.
    applyReset();
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) applyReset();
      lat = $urandom_range(1, 4);
      applyStimulus($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4,
                    $urandom(), $urandom_range(0, 99) < 70);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter FQ_DEPTH, default 2: instruction queue depth; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i_stall  input  1  from decode o_stall_to_if; head entry is held while high.
REQ-006 i_flush  input  1  redirect strobe; single cycle.
REQ-007 i_redirect_pc  input  32  new fetch address, sampled when i_flush is high.
REQ-008 o_imem_req  output  1  instruction memory request.
REQ-009 o_imem_addr  output  32  request word address; bits [1:0] are always 0.
REQ-010 i_imem_gnt  input  1  request accepted this cycle.
REQ-011 i_imem_rvalid  input  1  response valid; responses arrive in order, at least 1 cycle after grant.
REQ-012 i_imem_rdata  input  32  response instruction word.
REQ-013 o_if_valid  output  1  to decode i_if_valid.
REQ-014 o_if_pc  output  32  to decode i_if_pc.
REQ-015 o_if_instr  output  32  to decode i_if_instr.

Function
REQ-016 States: FS_BOOT, FS_RUN, FS_DRAIN, encoded as a 2-bit enum.
- Reset enters FS_BOOT.
- FS_BOOT goes to FS_RUN after one cycle, with no request in that cycle.
REQ-017 In FS_RUN, o_imem_req = !i_flush && (outstanding + fq_count < FQ_DEPTH); o_imem_addr = fetch PC.
REQ-018 On o_imem_req && i_imem_gnt:
- fetch PC advances by 4, wrapping modulo 2^32;
- the granted PC is pushed into the pending-PC FIFO;
- outstanding increments.
REQ-019 On i_imem_rvalid with drop_cnt == 0:
- pop the pending-PC FIFO;
- push {pc, rdata} into the instruction queue;
- outstanding decrements.
REQ-020 Grant and rvalid in the same cycle: outstanding is unchanged.
REQ-021 Credit rule (outstanding + fq_count <= FQ_DEPTH) guarantees the queue never overflows. A push to a full queue is an assertion failure.
REQ-022 o_if_valid = queue non-empty; o_if_pc and o_if_instr = head entry. All three are combinational from queue state.
REQ-023 Head pops when o_if_valid && !i_stall && !i_flush.
REQ-024 Push and pop in the same cycle are both performed.
REQ-025 While i_stall is high, the head entry stays unchanged; requests continue until credits are exhausted.
REQ-026 i_flush takes priority over every other event in the same cycle:
- queue cleared; o_if_valid is 0 the next cycle;
- pending-PC FIFO cleared;
- fetch PC <= {i_redirect_pc[31:2], 2'b00};
- o_imem_req held 0 that cycle.
REQ-027 Flush with drop count:
- drop_cnt <= outstanding, minus 1 if i_imem_rvalid is high that cycle (that response is discarded);
- if the resulting drop_cnt is nonzero, go to FS_DRAIN, else FS_RUN.
REQ-028 FS_DRAIN:
- o_imem_req = 0;
- each rvalid decrements drop_cnt and outstanding, and its data is discarded;
- go to FS_RUN in the cycle after drop_cnt reaches 0.
REQ-029 A flush in FS_DRAIN reloads fetch PC and recomputes drop_cnt per REQ-027.
REQ-030 A flush in FS_BOOT reloads fetch PC and goes to FS_RUN.
REQ-031 Counter widths are $clog2(FQ_DEPTH)+1 bits; counters never wrap.

Reset
REQ-032 On rst, the following take effect immediately, regardless of clk:
- state = FS_BOOT;
- fetch PC = RESET_PC with [1:0] forced to 0;
- queue, pending FIFO, outstanding and drop_cnt = 0;
- o_imem_req = 0, o_if_valid = 0, o_if_pc = 0, o_if_instr = 0.
REQ-033 Reset asserted mid-transaction abandons in-flight requests. The memory side is reset by the same rst.

Configuration
REQ-034 When FETCH_PERF_CNT_EN is defined, the block adds two 32-bit saturating output counters:
- o_perf_fetched: counts pops;
- o_perf_stall_cyc: counts cycles with o_if_valid && i_stall.
- Both reset to 0 and do not change on flush.
REQ-035 When FETCH_PERF_CNT_EN is undefined, neither the ports nor the logic exist.

Structure
REQ-036 fetch_state_t and the FETCH_NOP constant (32'h0000_0013) go in riscv_uop_pkg.
REQ-037 Pending-PC FIFO and instruction queue are both instances of one sub-module, fetch_fifo, with parameterised width and depth, synchronous clear, and full/empty/count outputs.

Verification
REQ-038 Bench must cover the following directed scenarios:
- Boot, RESET_PC=32'h8000_0000, gnt=1, rvalid 1 cycle later: first request to 80000000 in cycle 2; o_if_pc sequence 80000000, 80000004, 80000008.
- i_stall high 10 cycles with DEPTH=2: at most 2 requests granted beyond the held head; head pc/instr stable; no loss after release.
- Flush to 32'h0000_0102 with 2 outstanding: next request address 00000100; both stale responses dropped; o_if_valid stays 0 until the new response.
- Flush coinciding with rvalid and stall: that response discarded; drop_cnt = 1; state FS_DRAIN then FS_RUN.
- Fetch PC at FFFF_FFFC: next address 0000_0000.
- Reset asserted during FS_DRAIN: all outputs 0 without a clock edge; restart at RESET_PC.
